add_multi: RTL and testbench

ADD_MULTI -- requirements
Module: add_multi

---
 rtl/add_multi.sv | 146 ++++++++++++++
 tb/tb_add_multi.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/add_multi.sv
// Pipelined multi-operand adder: balanced binary tree over N summands with
// DEPTH enable-gated register stages and exact-width internal nodes.
package add_multi_pkg;

  // Minimal width holding [lo, hi]; two's complement when lo < 0.
  function automatic int bitwidth(longint lo, longint hi);
    int w;
    w = 1;
    if (lo >= 0) begin
      while ((longint'(1) << w) <= hi) w++;
    end else begin
      while ((lo < -(longint'(1) << (w - 1))) || (hi >= (longint'(1) << (w - 1)))) w++;
    end
    return w;
  endfunction

  function automatic int node_cnt(int n, int l);
    int c;
    c = n;
    for (int unsigned i = 0; i < unsigned'(l); i++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int tree_levels(int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 1) begin
      c = (c + 1) / 2;
      l++;
    end
    return l;
  endfunction

  // Width of a level-l node: it covers at most min(2^l, n) leaves.
  function automatic int node_width(int n, int l, int lo, int hi);
    longint k;
    k = longint'(1) << l;
    if (k > n) k = n;
    return bitwidth(k * lo, k * hi);
  endfunction

  function automatic bit reg_after(int l, int levels, int depth);
    if (depth >= levels) return 1'b1;
    return ((l * depth) / levels) > (((l - 1) * depth) / levels);
  endfunction

endpackage

module add_multi
  import add_multi_pkg::*;
#(
  parameter int N         = 8,
  parameter int DEPTH     = 2,
  parameter int ARG_LO    = -1,
  parameter int ARG_HI    = 1,
  parameter int ARG_WIDTH = bitwidth(ARG_LO, ARG_HI),
  localparam int SUM_WIDTH = bitwidth(longint'(N) * ARG_LO, longint'(N) * ARG_HI)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ARG_WIDTH-1:0] arg [N],
  output logic [SUM_WIDTH-1:0] sum
);

  localparam bit SIGNED = (ARG_LO < 0);
  localparam int LEVELS = tree_levels(N);
  localparam int EXTRA  = (DEPTH > LEVELS) ? DEPTH - LEVELS : 0;

  logic [SUM_WIDTH-1:0] tree_out;

  for (genvar l = 1; l <= LEVELS; l++) begin : lvl
    localparam int CNT  = node_cnt(N, l);
    localparam int PCNT = node_cnt(N, l - 1);
    localparam int W    = node_width(N, l, ARG_LO, ARG_HI);
    localparam int PW   = (l == 1) ? ARG_WIDTH : node_width(N, l - 1, ARG_LO, ARG_HI);

    logic [PW-1:0] src    [2*CNT];
    logic [W-1:0]  node_d [CNT];
    logic [W-1:0]  node   [CNT];

    // Odd leftover node is paired with a zero so every node is a uniform add.
    for (genvar j = 0; j < 2 * CNT; j++) begin : g_src
      if (j >= PCNT) begin : g_pad
        assign src[j] = '0;
      end else if (l == 1) begin : g_arg
        assign src[j] = arg[j];
      end else begin : g_prev
        assign src[j] = lvl[l-1].node[j];
      end
    end

    always_comb begin
      for (int unsigned i = 0; i < unsigned'(CNT); i++) begin
        if (SIGNED) node_d[i] = W'($signed(src[2*i])) + W'($signed(src[2*i+1]));
        else        node_d[i] = W'(src[2*i]) + W'(src[2*i+1]);
      end
    end

    if (reg_after(l, LEVELS, DEPTH)) begin : g_reg
      logic [W-1:0] node_q [CNT];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned i = 0; i < unsigned'(CNT); i++) node_q[i] <= '0;
        end else if (en) begin
          node_q <= node_d;
        end
      end
      assign node = node_q;
    end else begin : g_comb
      assign node = node_d;
    end
  end

  if (LEVELS == 0) begin : g_leaf
    always_comb begin
      if (SIGNED) tree_out = SUM_WIDTH'($signed(arg[0]));
      else        tree_out = SUM_WIDTH'(arg[0]);
    end
  end else begin : g_root
    assign tree_out = lvl[LEVELS].node[0];
  end

  // Stages beyond one-per-level become a plain delay line on the result.
  if (EXTRA > 0) begin : g_dly
    logic [SUM_WIDTH-1:0] dly_d [EXTRA];
    logic [SUM_WIDTH-1:0] dly_q [EXTRA];
    always_comb begin
      dly_d[0] = tree_out;
      for (int unsigned i = 1; i < unsigned'(EXTRA); i++) dly_d[i] = dly_q[i-1];
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < unsigned'(EXTRA); i++) dly_q[i] <= '0;
      end else if (en) begin
        dly_q <= dly_d;
      end
    end
    assign sum = dly_q[EXTRA-1];
  end else begin : g_nodly
    assign sum = tree_out;
  end

endmodule

// File: tb/tb_add_multi.sv
// Bench for add_multi: several parameterisations driven in lockstep; a queue
// per instance holds reference sums and is popped on every enabled edge.
module tb_add_multi;

  logic clk, rst, en;

  logic [1:0] a7  [7];  logic [3:0]  s7;
  logic [2:0] a5  [5];  logic [5:0]  s5;
  logic [1:0] a16 [16]; logic [5:0]  s16;
  logic [5:0] a33 [33]; logic [10:0] s33;
  logic [5:0] a31 [31]; logic [9:0]  s31;
  logic [4:0] a8  [8];  logic [7:0]  s8;

  add_multi #(.N(7),  .DEPTH(4), .ARG_LO(-1), .ARG_HI(1))  u7  (.clk(clk), .rst(rst), .en(en), .arg(a7),  .sum(s7));
  add_multi #(.N(5),  .DEPTH(0), .ARG_LO(0),  .ARG_HI(7))  u5  (.clk(clk), .rst(rst), .en(en), .arg(a5),  .sum(s5));
  add_multi #(.N(16), .DEPTH(2), .ARG_LO(-1), .ARG_HI(1))  u16 (.clk(clk), .rst(rst), .en(en), .arg(a16), .sum(s16));
  add_multi #(.N(33), .DEPTH(7), .ARG_LO(0),  .ARG_HI(33)) u33 (.clk(clk), .rst(rst), .en(en), .arg(a33), .sum(s33));
  add_multi #(.N(31), .DEPTH(5), .ARG_LO(0),  .ARG_HI(33)) u31 (.clk(clk), .rst(rst), .en(en), .arg(a31), .sum(s31));
  add_multi #(.N(8),  .DEPTH(4), .ARG_LO(0),  .ARG_HI(16)) u8  (.clk(clk), .rst(rst), .en(en), .arg(a8),  .sum(s8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int q7[$], q16[$], q33[$], q31[$], q8[$];
  int e7, e16, e33, e31, e8;

  typedef struct packed {
    logic [14:0] args;
    int          expected;
  } vec5_t;
  vec5_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int mode, input int lo, input int hi);
    if (mode == 1) return hi;
    if (mode == 2) return lo;
    return lo + int'($urandom_range(hi - lo));
  endfunction

  // Queues start with DEPTH-1 zeros: after a push, the popped head is the
  // value the output shows right after that enabled edge.
  task automatic reset_model();
    q7 = {};  repeat (3) q7.push_back(0);
    q16 = {}; repeat (1) q16.push_back(0);
    q33 = {}; repeat (6) q33.push_back(0);
    q31 = {}; repeat (4) q31.push_back(0);
    q8 = {};  repeat (3) q8.push_back(0);
    e7 = 0; e16 = 0; e33 = 0; e31 = 0; e8 = 0;
  endtask

  task automatic zero_args();
    for (int i = 0; i < 7; i++)  a7[i]  = '0;
    for (int i = 0; i < 5; i++)  a5[i]  = '0;
    for (int i = 0; i < 16; i++) a16[i] = '0;
    for (int i = 0; i < 33; i++) a33[i] = '0;
    for (int i = 0; i < 31; i++) a31[i] = '0;
    for (int i = 0; i < 8; i++)  a8[i]  = '0;
  endtask

  task automatic check_piped_zero(input string tag);
    check({tag, "_n7"},  int'($signed(s7)),  0);
    check({tag, "_n16"}, int'($signed(s16)), 0);
    check({tag, "_n33"}, int'(s33), 0);
    check({tag, "_n31"}, int'(s31), 0);
    check({tag, "_n8"},  int'(s8),  0);
  endtask

  // Entered at posedge+1; drives new args, crosses one edge, checks at posedge+1.
  task automatic step(input int mode);
    int r7, r5, r16, r33, r31, r8, v;
    r7 = 0; r5 = 0; r16 = 0; r33 = 0; r31 = 0; r8 = 0;
    for (int i = 0; i < 7; i++)  begin v = pick(mode, -1, 1); a7[i]  = 2'(v); r7  += v; end
    for (int i = 0; i < 5; i++)  begin v = pick(mode, 0, 7);  a5[i]  = 3'(v); r5  += v; end
    for (int i = 0; i < 16; i++) begin v = pick(mode, -1, 1); a16[i] = 2'(v); r16 += v; end
    for (int i = 0; i < 33; i++) begin v = pick(mode, 0, 33); a33[i] = 6'(v); r33 += v; end
    for (int i = 0; i < 31; i++) begin v = pick(mode, 0, 33); a31[i] = 6'(v); r31 += v; end
    for (int i = 0; i < 8; i++)  begin v = pick(mode, 0, 16); a8[i]  = 5'(v); r8  += v; end
    #1;
    check("n5_comb", int'(s5), r5);
    @(posedge clk);
    if (en) begin
      q7.push_back(r7);   e7  = q7.pop_front();
      q16.push_back(r16); e16 = q16.pop_front();
      q33.push_back(r33); e33 = q33.pop_front();
      q31.push_back(r31); e31 = q31.pop_front();
      q8.push_back(r8);   e8  = q8.pop_front();
    end
    #1;
    check("n7_d4",  int'($signed(s7)),  e7);
    check("n16_d2", int'($signed(s16)), e16);
    check("n33_d7", int'(s33), e33);
    check("n31_d5", int'(s31), e31);
    check("n8_d4",  int'(s8),  e8);
  endtask

  // Entered at posedge+1 with the pipelines holding live data.
  task automatic do_reset();
    zero_args();
    for (int i = 0; i < 5; i++) a5[i] = 3'd7;
    #2 rst = 1'b0;
    #1;
    check_piped_zero("rst_async");
    check("rst_n5_follows", int'(s5), 35);
    reset_model();
    @(posedge clk);
    #1;
    check_piped_zero("rst_held");
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    en       = 1'b1;
    zero_args();
    reset_model();

    tbl[0] = '{args: {5{3'd7}},                         expected: 35};
    tbl[1] = '{args: {5{3'd0}},                         expected: 0};
    tbl[2] = '{args: {3'd5, 3'd4, 3'd3, 3'd2, 3'd1},    expected: 15};
    tbl[3] = '{args: {3'd7, 3'd0, 3'd7, 3'd0, 3'd7},    expected: 21};
    tbl[4] = '{args: {3'd0, 3'd0, 3'd0, 3'd0, 3'd1},    expected: 1};
    tbl[5] = '{args: {5{3'd6}},                         expected: 30};

    #3;
    check_piped_zero("reset");
    check("reset_n5", int'(s5), 0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 5; i++) a5[i] = tbl[t].args[3*i +: 3];
      #1;
      check($sformatf("n5_tbl%0d", t), int'(s5), tbl[t].expected);
    end
    for (int i = 0; i < 5; i++) a5[i] = '0;
    @(posedge clk);
    #1;

    repeat (6) step(1);
    repeat (6) step(2);
    repeat (509) step(0);

    en = 1'b0;
    repeat (3) step(0);
    en = 1'b1;
    repeat (20) step(0);

    do_reset();
    repeat (8) step(1);
    repeat (8) step(0);
    repeat (8) step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
